// File: rtl/ifft_sched_pkg.sv
// Shared types and constants for the IFFT frame scheduler.
package ifft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int   FRAME_LEN = 64;
  localparam logic SRC_TRN   = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

endpackage

// File: rtl/ifft_frame_sched_if.sv
// Bundle of requester, IFFT-input and IFFT-output signals around the frame scheduler.
interface ifft_frame_sched_if #(
  parameter int WIDTH = 16
);
  // Handshake: sN_req is a level "frame ready" held until sN_rd is first seen;
  // sN_rd high means the sample on sN_real/sN_imag is consumed at that clock edge.
  // din_valid qualifies ifft_*_din each cycle with no backpressure.
  logic             s0_req;
  logic             s0_rd;
  logic [WIDTH-1:0] s0_real;
  logic [WIDTH-1:0] s0_imag;
  logic             s1_req;
  logic             s1_rd;
  logic [WIDTH-1:0] s1_real;
  logic [WIDTH-1:0] s1_imag;
  logic             din_valid;
  logic [WIDTH-1:0] ifft_real_din;
  logic [WIDTH-1:0] ifft_imag_din;
  logic             dout_valid;
  logic [5:0]       dout_index;
  logic             out_src;
  logic             out_sop;
  logic [15:0]      frames_sent;
  logic             tag_err;

  modport master (
    input  s0_req, s0_real, s0_imag, s1_req, s1_real, s1_imag, dout_valid, dout_index,
    output s0_rd, s1_rd, din_valid, ifft_real_din, ifft_imag_din,
    output out_src, out_sop, frames_sent, tag_err
  );

  modport slave (
    output s0_req, s0_real, s0_imag, s1_req, s1_real, s1_imag, dout_valid, dout_index,
    input  s0_rd, s1_rd, din_valid, ifft_real_din, ifft_imag_din,
    input  out_src, out_sop, frames_sent, tag_err
  );

endinterface

// File: rtl/ifft_tag_fifo.sv
// 1-bit source-tag FIFO tracking frames in flight through the IFFT core.
module ifft_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifft_frame_sched.sv
// Grants the shared 64-point IFFT to src0/src1 a whole frame at a time and
// tags each output frame with the requester that produced it.
module ifft_frame_sched #(
  parameter int WIDTH     = 16,
  parameter int GAP       = 1,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         ifft_clk,
  input  logic                         ifft_rst,
  ifft_frame_sched_if.master           bus,
  output ifft_sched_pkg::sched_state_t state_dbg
);
  import ifft_sched_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  sched_state_t     state;
  sched_state_t     next_state;
  logic [5:0]       cnt;
  logic [3:0]       gcnt;
  logic             sel_src;
  logic             sel_rd;
  logic             grant;
  logic             grant_src;
  logic [15:0]      frames_sent_q;
  logic             din_valid_q;
  logic [WIDTH-1:0] real_q;
  logic [WIDTH-1:0] imag_q;
  logic             out_src_q;
  logic             out_sop_q;
  logic             tag_err_q;
  logic             tag_full;
  logic             tag_empty;
  logic             tag_head;
  logic             tag_pop;
  logic             sop_hit;

  assign sel_rd  = (state == BURST);
  assign tag_pop = bus.dout_valid && (bus.dout_index == LAST_IDX);
  assign sop_hit = bus.dout_valid && (bus.dout_index == 6'd0);

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_src  = bus.s0_req ? SRC_TRN : SRC_DATA;
    case (state)
      IDLE: begin
        // Full is the pre-pop count: a frame finishing this cycle frees a slot next cycle.
        if (!tag_full && (bus.s0_req || bus.s1_req)) begin
          grant      = 1'b1;
          next_state = BURST;
        end
      end
      BURST: if (cnt == LAST_IDX) next_state = ifft_sched_pkg::GAP;
      ifft_sched_pkg::GAP: if (gcnt == 4'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ifft_clk) begin
    if (ifft_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      gcnt          <= '0;
      sel_src       <= SRC_TRN;
      frames_sent_q <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        sel_src       <= grant_src;
        cnt           <= '0;
        frames_sent_q <= frames_sent_q + 16'd1;
      end else if (state == BURST) begin
        cnt <= cnt + 6'd1;
      end
      if (state == BURST && next_state == ifft_sched_pkg::GAP) gcnt <= GAP_LOAD;
      else if (state == ifft_sched_pkg::GAP && gcnt != 4'd0) gcnt <= gcnt - 4'd1;
    end
  end

  always_ff @(posedge ifft_clk) begin
    if (ifft_rst || !sel_rd) begin
      din_valid_q <= 1'b0;
      real_q      <= '0;
      imag_q      <= '0;
    end else begin
      din_valid_q <= 1'b1;
      real_q      <= (sel_src == SRC_DATA) ? bus.s1_real : bus.s0_real;
      imag_q      <= (sel_src == SRC_DATA) ? bus.s1_imag : bus.s0_imag;
    end
  end

  always_ff @(posedge ifft_clk) begin
    if (ifft_rst) begin
      out_src_q <= 1'b0;
      out_sop_q <= 1'b0;
      tag_err_q <= 1'b0;
    end else begin
      out_sop_q <= sop_hit;
      if (sop_hit && !tag_empty) out_src_q <= tag_head;
      if (bus.dout_valid && tag_empty) tag_err_q <= 1'b1;
    end
  end

  ifft_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk   (ifft_clk),
    .rst   (ifft_rst),
    .push  (grant),
    .pop   (tag_pop),
    .din   (grant_src),
    .full  (tag_full),
    .empty (tag_empty),
    .head  (tag_head)
  );

  assign bus.s0_rd         = sel_rd && (sel_src == SRC_TRN);
  assign bus.s1_rd         = sel_rd && (sel_src == SRC_DATA);
  assign bus.din_valid     = din_valid_q;
  assign bus.ifft_real_din = real_q;
  assign bus.ifft_imag_din = imag_q;
  assign bus.out_src       = out_src_q;
  assign bus.out_sop       = out_sop_q;
  assign bus.frames_sent   = frames_sent_q;
  assign bus.tag_err       = tag_err_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_ifft_frame_sched.sv
// Directed bench for ifft_frame_sched: GAP=1 instance for most steps, GAP=3 instance for back-to-back frames.
module tb_ifft_frame_sched;
  import ifft_sched_pkg::*;

  logic ifft_clk = 1'b0;
  logic ifft_rst = 1'b1;
  always #5 ifft_clk = ~ifft_clk;

  ifft_frame_sched_if #(.WIDTH(16)) bus_a ();
  ifft_frame_sched_if #(.WIDTH(16)) bus_b ();
  sched_state_t state_a;
  sched_state_t state_b;

  ifft_frame_sched #(.WIDTH(16), .GAP(1), .TAG_DEPTH(4)) dut (
    .ifft_clk  (ifft_clk),
    .ifft_rst  (ifft_rst),
    .bus       (bus_a.master),
    .state_dbg (state_a)
  );

  ifft_frame_sched #(.WIDTH(16), .GAP(3), .TAG_DEPTH(4)) dut_g3 (
    .ifft_clk  (ifft_clk),
    .ifft_rst  (ifft_rst),
    .bus       (bus_b.master),
    .state_dbg (state_b)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int idx0, idx1, cyc, rd0_cyc, rd1_cyc, first_rd0, first_rd1;
  int dv_cyc, dv_runs, idle_run, last_gap;
  bit prev_rd0, prev_rd1, prev_dv, seen_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    bus_a.s0_real = 16'h1000 + idx0[15:0];
    bus_a.s0_imag = 16'h2000 + idx0[15:0];
    bus_a.s1_real = idx1[15:0];
    bus_a.s1_imag = 16'h8000 + idx1[15:0];
  endtask

  task automatic model_clear();
    idx0 = 0; idx1 = 0; cyc = 0;
    rd0_cyc = 0; rd1_cyc = 0; first_rd0 = 0; first_rd1 = 0;
    dv_cyc = 0; dv_runs = 0; idle_run = 0; last_gap = -1;
    prev_rd0 = 0; prev_rd1 = 0; prev_dv = 0; seen_dv = 0;
    exp_q.delete();
    drive_src();
  endtask

  task automatic do_reset();
    ifft_rst = 1'b1;
    bus_a.s0_req = 1'b0; bus_a.s1_req = 1'b0; bus_a.dout_valid = 1'b0; bus_a.dout_index = 6'd0;
    bus_b.s0_req = 1'b0; bus_b.s1_req = 1'b0; bus_b.dout_valid = 1'b0; bus_b.dout_index = 6'd0;
    repeat (2) @(negedge ifft_clk);
    ifft_rst = 1'b0;
    model_clear();
  endtask

  // One clock on the GAP=1 instance: source model, request release and sample scoreboard.
  task automatic step();
    @(negedge ifft_clk);
    cyc++;
    if (prev_rd0) idx0++;
    if (prev_rd1) idx1++;
    drive_src();
    if (bus_a.s0_rd) begin
      rd0_cyc++;
      if (first_rd0 == 0) first_rd0 = cyc;
      exp_q.push_back({16'h1000 + idx0[15:0], 16'h2000 + idx0[15:0]});
      bus_a.s0_req = 1'b0;
    end
    if (bus_a.s1_rd) begin
      rd1_cyc++;
      if (first_rd1 == 0) first_rd1 = cyc;
      exp_q.push_back({idx1[15:0], 16'h8000 + idx1[15:0]});
      bus_a.s1_req = 1'b0;
    end
    prev_rd0 = bus_a.s0_rd;
    prev_rd1 = bus_a.s1_rd;
    if (bus_a.din_valid) begin
      dv_cyc++;
      if (!prev_dv) begin
        if (seen_dv) last_gap = idle_run;
        dv_runs++;
      end
      seen_dv = 1;
      idle_run = 0;
      if (exp_q.size() == 0) chk("din_unexpected", 32'd1, 32'd0);
      else chk("din_sample", {bus_a.ifft_real_din, bus_a.ifft_imag_din}, exp_q.pop_front());
    end else begin
      idle_run++;
      chk("din_idle_zero", {bus_a.ifft_real_din, bus_a.ifft_imag_din}, 32'd0);
    end
    prev_dv = bus_a.din_valid;
  endtask

  initial begin
    int lat;
    int runs_b, idle_b;
    bit prev_b, seen_b;

    bus_a.s0_req = 1'b0; bus_a.s1_req = 1'b0; bus_a.dout_valid = 1'b0; bus_a.dout_index = 6'd0;
    bus_b.s0_req = 1'b0; bus_b.s1_req = 1'b0; bus_b.dout_valid = 1'b0; bus_b.dout_index = 6'd0;
    bus_b.s0_real = 16'h0; bus_b.s0_imag = 16'h0; bus_b.s1_real = 16'h5a5a; bus_b.s1_imag = 16'ha5a5;
    model_clear();

    // Reset values
    repeat (2) @(negedge ifft_clk);
    chk("rst_s0_rd", bus_a.s0_rd, 0);
    chk("rst_s1_rd", bus_a.s1_rd, 0);
    chk("rst_din_valid", bus_a.din_valid, 0);
    chk("rst_din", {bus_a.ifft_real_din, bus_a.ifft_imag_din}, 0);
    chk("rst_out", {bus_a.out_src, bus_a.out_sop, bus_a.tag_err}, 0);
    chk("rst_frames", bus_a.frames_sent, 0);
    chk("rst_state", state_a, IDLE);
    ifft_rst = 1'b0;
    model_clear();

    // Single src1 frame carrying 0..63
    bus_a.s1_req = 1'b1;
    repeat (70) step();
    chk("t1_first_rd", first_rd1, 1);
    chk("t1_rd_cycles", rd1_cyc, 64);
    chk("t1_src0_idle", rd0_cyc, 0);
    chk("t1_dv_cycles", dv_cyc, 64);
    chk("t1_dv_runs", dv_runs, 1);
    chk("t1_exp_drained", exp_q.size(), 0);
    chk("t1_frames", bus_a.frames_sent, 1);

    // Both requesters in IDLE: src0 first, src1 after the gap
    do_reset();
    bus_a.s0_req = 1'b1;
    bus_a.s1_req = 1'b1;
    repeat (140) step();
    chk("t2_first_rd0", first_rd0, 1);
    chk("t2_first_rd1", first_rd1, 67);
    chk("t2_rd0_cycles", rd0_cyc, 64);
    chk("t2_rd1_cycles", rd1_cyc, 64);
    chk("t2_dv_runs", dv_runs, 2);
    chk("t2_gap", last_gap, 2);
    chk("t2_frames", bus_a.frames_sent, 2);

    // Model IFFT output for the two frames just granted (src0 then src1)
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) begin
        bus_a.dout_valid = 1'b1;
        bus_a.dout_index = 6'(i);
        step();
        chk("t4_out_src", bus_a.out_src, f);
        chk("t4_out_sop", bus_a.out_sop, (i == 0) ? 1 : 0);
      end
    end
    bus_a.dout_valid = 1'b0;
    step();
    chk("t4_sop_low", bus_a.out_sop, 0);
    chk("t4_no_tag_err", bus_a.tag_err, 0);
    chk("t4_fifo_empty", dut.u_tags.empty, 1);

    // Reset in the middle of a burst at cnt = 30
    do_reset();
    bus_a.s0_req = 1'b1;
    for (int k = 0; k < 40 && rd0_cyc < 31; k++) step();
    chk("t5_reached_cnt30", rd0_cyc, 31);
    ifft_rst = 1'b1;
    @(negedge ifft_clk);
    chk("t5_rd_low", {bus_a.s0_rd, bus_a.s1_rd}, 0);
    chk("t5_dv_low", bus_a.din_valid, 0);
    chk("t5_din_zero", {bus_a.ifft_real_din, bus_a.ifft_imag_din}, 0);
    chk("t5_frames", bus_a.frames_sent, 0);
    chk("t5_state", state_a, IDLE);
    chk("t5_fifo_empty", dut.u_tags.empty, 1);
    ifft_rst = 1'b0;
    model_clear();
    bus_a.s0_req = 1'b1;
    repeat (70) step();
    chk("t5_rd_cycles", rd0_cyc, 64);
    chk("t5_dv_cycles", dv_cyc, 64);
    chk("t5_exp_drained", exp_q.size(), 0);
    chk("t5_frames_after", bus_a.frames_sent, 1);

    // Output activity with nothing in flight
    do_reset();
    bus_a.dout_valid = 1'b1;
    bus_a.dout_index = 6'd5;
    step();
    bus_a.dout_valid = 1'b0;
    chk("t6_tag_err_set", bus_a.tag_err, 1);
    repeat (10) step();
    chk("t6_tag_err_sticky", bus_a.tag_err, 1);
    ifft_rst = 1'b1;
    @(negedge ifft_clk);
    chk("t6_tag_err_cleared", bus_a.tag_err, 0);
    ifft_rst = 1'b0;
    model_clear();

    // GAP=3, src1 holds req: 4-cycle gaps, stall at 4 frames until index 63 emerges
    do_reset();
    bus_b.s1_req = 1'b1;
    runs_b = 0; idle_b = 0; prev_b = 0; seen_b = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ifft_clk);
      if (bus_b.din_valid) begin
        if (!prev_b) begin
          if (seen_b) chk("t3_gap", idle_b, 4);
          runs_b++;
        end
        seen_b = 1;
        idle_b = 0;
      end else begin
        idle_b++;
      end
      prev_b = bus_b.din_valid;
    end
    chk("t3_frames_stalled", bus_b.frames_sent, 4);
    chk("t3_dv_runs", runs_b, 4);
    chk("t3_rd_stalled", bus_b.s1_rd, 0);
    chk("t3_state_idle", state_b, IDLE);
    bus_b.dout_valid = 1'b1;
    bus_b.dout_index = 6'd63;
    @(negedge ifft_clk);
    bus_b.dout_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      if (bus_b.s1_rd && lat == 0) lat = k;
      @(negedge ifft_clk);
    end
    chk("t3_refill_latency", lat, 2);
    chk("t3_frames_after", bus_b.frames_sent, 5);
    chk("t3_no_tag_err", bus_b.tag_err, 0);
    bus_b.s1_req = 1'b0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
